// File: rtl/net_mii_tx.sv
// MII transmit engine: preamble/SFD, FIFO-fed payload nibbles, nibble-serial CRC-32 FCS,
// underflow abort and inter-frame gap. One nibble per clk; all MII outputs registered.
module net_mii_tx #(
   parameter int unsigned ADDR_WIDTH  = 6,
   parameter int unsigned IFG_NIBBLES = 24
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tx_start_i,
   input  logic [10:0]           tx_len_i,
   input  logic [ADDR_WIDTH-1:0] fifo_cnt_i,
   input  logic [31:0]           fifo_rdata_i,
   output logic                  fifo_rd_o,
   output logic [3:0]            mii_txd_o,
   output logic                  mii_tx_en_o,
   output logic                  mii_tx_er_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  underflow_o
);

   typedef enum logic [2:0] {StIdle, StPre, StData, StFcs, StAbort, StIfg} state_e;

   localparam logic [31:0] CrcPoly = 32'hEDB8_8320;
   localparam logic [11:0] IfgLast = 12'(IFG_NIBBLES - 1);

   state_e      state_q;
   logic [11:0] cnt_q;
   logic [10:0] len_q;
   logic [2:0]  nib_q;
   logic [31:0] shift_q;
   logic [31:0] crc_q;
   logic [3:0]  txd_q;
   logic        tx_en_q;
   logic        tx_er_q;
   logic        done_q;
   logic        underflow_q;
   logic        fetch;
   logic        word_ok;

   function automatic logic [31:0] crc_nibble(input logic [31:0] crc, input logic [3:0] nib);
      logic [31:0] c;
      c = crc ^ {28'd0, nib};
      for (int i = 0; i < 4; i++) begin
         c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
      end
      return c;
   endfunction

   // State/counters describe the nibble currently on mii_txd; a fetch happens while the
   // last PRE nibble or the last nibble of a word (with payload left) is being driven.
   assign fetch   = (state_q == StPre && cnt_q == '0) ||
                    (state_q == StData && cnt_q != '0 && nib_q == 3'd7);
   assign word_ok = (fifo_cnt_i != '0);

   assign fifo_rd_o   = fetch & word_ok;
   assign mii_txd_o   = txd_q;
   assign mii_tx_en_o = tx_en_q;
   assign mii_tx_er_o = tx_er_q;
   assign busy_o      = (state_q != StIdle);
   assign done_o      = done_q;
   assign underflow_o = underflow_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         len_q       <= '0;
         nib_q       <= '0;
         shift_q     <= '0;
         crc_q       <= '0;
         txd_q       <= '0;
         tx_en_q     <= 1'b0;
         tx_er_q     <= 1'b0;
         done_q      <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         done_q      <= 1'b0;
         underflow_q <= 1'b0;
         tx_er_q     <= 1'b0;
         if (fetch) begin
            if (word_ok) begin
               state_q <= StData;
               shift_q <= fifo_rdata_i;
               txd_q   <= fifo_rdata_i[3:0];
               crc_q   <= crc_nibble(crc_q, fifo_rdata_i[3:0]);
               nib_q   <= 3'd0;
               cnt_q   <= (state_q == StPre) ? ({len_q, 1'b0} - 12'd1) : (cnt_q - 12'd1);
            end else begin
               state_q     <= StAbort;
               txd_q       <= 4'h0;
               tx_er_q     <= 1'b1;
               underflow_q <= 1'b1;
            end
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (tx_start_i && tx_len_i != '0) begin
                     state_q <= StPre;
                     len_q   <= tx_len_i;
                     cnt_q   <= 12'd15;
                     crc_q   <= '1;
                     txd_q   <= 4'h5;
                     tx_en_q <= 1'b1;
                  end
               end
               StPre: begin
                  cnt_q <= cnt_q - 12'd1;
                  txd_q <= (cnt_q == 12'd1) ? 4'hD : 4'h5;
               end
               StData: begin
                  if (cnt_q == '0) begin
                     state_q <= StFcs;
                     shift_q <= ~crc_q;
                     txd_q   <= ~crc_q[3:0];
                     cnt_q   <= 12'd7;
                  end else begin
                     shift_q <= shift_q >> 4;
                     txd_q   <= shift_q[7:4];
                     crc_q   <= crc_nibble(crc_q, shift_q[7:4]);
                     nib_q   <= nib_q + 3'd1;
                     cnt_q   <= cnt_q - 12'd1;
                  end
               end
               StFcs, StAbort: begin
                  if (state_q == StFcs && cnt_q != '0) begin
                     shift_q <= shift_q >> 4;
                     txd_q   <= shift_q[7:4];
                     cnt_q   <= cnt_q - 12'd1;
                  end else begin
                     state_q <= StIfg;
                     txd_q   <= 4'h0;
                     tx_en_q <= 1'b0;
                     cnt_q   <= IfgLast;
                     done_q  <= (IfgLast == '0);
                  end
               end
               StIfg: begin
                  if (cnt_q == '0) begin
                     state_q <= StIdle;
                  end else begin
                     cnt_q  <= cnt_q - 12'd1;
                     done_q <= (cnt_q == 12'd1);
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_net_mii_tx.sv
// Bench for net_mii_tx: FIFO model plus a frame-level reference built from byte payloads
// (bytewise CRC-32), compared cycle by cycle against the MII outputs.
module tb_net_mii_tx;

   localparam int unsigned AW  = 6;
   localparam int unsigned IFG = 24;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tx_start = 1'b0;
   logic [10:0]   tx_len = '0;
   logic [AW-1:0] fifo_cnt;
   logic [31:0]   fifo_rdata;
   logic          fifo_rd;
   logic [3:0]    mii_txd;
   logic          mii_tx_en;
   logic          mii_tx_er;
   logic          busy;
   logic          done;
   logic          underflow;

   logic [31:0] mem [0:255];
   int          wr_ptr = 0;
   int          rd_ptr = 0;
   int          pops = 0;
   int          bad_pops = 0;
   int          checks = 0;
   int          failures = 0;
   int          en_cycles = 0;
   logic [31:0] pend [$];
   logic [8:0]  exp_q [$];
   logic [3:0]  obs_txd [0:511];
   logic [3:0]  gold_fcs [0:7] = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};

   net_mii_tx #(.ADDR_WIDTH(AW), .IFG_NIBBLES(IFG)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tx_start_i   (tx_start),
      .tx_len_i     (tx_len),
      .fifo_cnt_i   (fifo_cnt),
      .fifo_rdata_i (fifo_rdata),
      .fifo_rd_o    (fifo_rd),
      .mii_txd_o    (mii_txd),
      .mii_tx_en_o  (mii_tx_en),
      .mii_tx_er_o  (mii_tx_er),
      .busy_o       (busy),
      .done_o       (done),
      .underflow_o  (underflow)
   );

   always #5 clk = ~clk;

   assign fifo_cnt   = AW'(wr_ptr - rd_ptr);
   assign fifo_rdata = mem[rd_ptr[7:0]];

   always @(posedge clk) begin
      if (fifo_rd) begin
         pops <= pops + 1;
         if (fifo_cnt == '0) bad_pops <= bad_pops + 1;
         else rd_ptr <= rd_ptr + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] w);
      mem[wr_ptr[7:0]] = w;
      wr_ptr = wr_ptr + 1;
      pend.push_back(w);
   endtask

   // Expected {busy, tx_en, tx_er, txd, done, underflow} per cycle after acceptance.
   task automatic build_exp(input int len, output int exp_pops);
      int          need, avail, nbytes;
      logic [7:0]  bytes [$];
      logic [31:0] w, c;
      exp_q.delete();
      need = (len + 3) / 4;
      for (int i = 0; i < 15; i++) exp_q.push_back({3'b110, 4'h5, 2'b00});
      exp_q.push_back({3'b110, 4'hD, 2'b00});
      avail    = (pend.size() < need) ? pend.size() : need;
      exp_pops = avail;
      nbytes   = (avail == need) ? len : 4 * avail;
      for (int b = 0; b < nbytes; b++) begin
         w = pend[b / 4];
         bytes.push_back(w[8 * (b % 4) +: 8]);
      end
      foreach (bytes[b]) begin
         exp_q.push_back({3'b110, bytes[b][3:0], 2'b00});
         exp_q.push_back({3'b110, bytes[b][7:4], 2'b00});
      end
      if (avail == need) begin
         c = 32'hFFFF_FFFF;
         foreach (bytes[b]) begin
            c = c ^ {24'd0, bytes[b]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
         end
         c = ~c;
         for (int k = 0; k < 8; k++) exp_q.push_back({3'b110, c[4 * k +: 4], 2'b00});
      end else begin
         exp_q.push_back({3'b111, 4'h0, 2'b01});
      end
      for (int k = 1; k <= IFG; k++) exp_q.push_back({3'b100, 4'h0, (k == IFG), 1'b0});
      exp_q.push_back(9'h000);
   endtask

   // Called just after a falling edge; the next rising edge should accept the frame.
   task automatic run_frame(input int len, input bit poke);
      int ep, p0, n;
      build_exp(len, ep);
      p0        = pops;
      en_cycles = 0;
      tx_start  = 1'b1;
      tx_len    = 11'(len);
      @(negedge clk);
      tx_start = 1'b0;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         if (i > 0) @(negedge clk);
         obs_txd[i] = mii_txd;
         if (mii_tx_en) en_cycles++;
         chk($sformatf("len%0d_cyc%0d", len, i + 1),
             {23'd0, busy, mii_tx_en, mii_tx_er, mii_txd, done, underflow}, {23'd0, exp_q[i]});
         if (poke && (i == 24 || i == n - 6)) begin
            tx_start = 1'b1;
            tx_len   = 11'($urandom_range(0, 2047));
         end else begin
            tx_start = 1'b0;
         end
      end
      chk($sformatf("len%0d_pops", len), pops - p0, ep);
      repeat (ep) void'(pend.pop_front());
   endtask

   initial begin
      int len, need;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_outputs", {22'd0, fifo_rd, mii_txd, mii_tx_en, mii_tx_er, busy, done, underflow},
          32'd0);
      @(negedge clk);

      // Golden "123456789" frame, accepted on the first edge after reset release.
      push(32'h3433_3231);
      push(32'h3837_3635);
      push(32'h0000_0039);
      rst_n = 1'b1;
      run_frame(9, 1'b0);
      chk("golden_en_cycles", en_cycles, 42);
      for (int k = 0; k < 8; k++) chk($sformatf("golden_fcs%0d", k), obs_txd[34 + k], gold_fcs[k]);

      // Minimum frame.
      push(32'hDDCC_BBAA);
      run_frame(1, 1'b0);
      chk("min_en_cycles", en_cycles, 26);
      chk("min_nib0", obs_txd[16], 32'hA);
      chk("min_nib1", obs_txd[17], 32'hA);

      // Underflow: only one of two needed words present.
      push($urandom);
      run_frame(8, 1'b0);
      chk("uflow_en_cycles", en_cycles, 25);

      // Zero length request is ignored.
      tx_start = 1'b1;
      tx_len   = '0;
      @(negedge clk);
      tx_start = 1'b0;
      chk("zero_len_busy", busy, 0);
      @(negedge clk);
      chk("zero_len_tx_en", mii_tx_en, 0);

      // Requests during DATA and IFG are ignored; next frame follows immediately.
      for (int i = 0; i < 3; i++) push($urandom);
      run_frame(10, 1'b1);
      push($urandom);
      run_frame(3, 1'b0);

      // Random frames, some short of words.
      for (int f = 0; f < 8; f++) begin
         len  = $urandom_range(1, 60);
         need = (len + 3) / 4;
         if ($urandom_range(0, 3) == 0) need = need - 1;
         for (int i = 0; i < need; i++) push($urandom);
         run_frame(len, 1'b0);
      end

      // Reset during the third data nibble.
      push($urandom);
      push($urandom);
      begin
         int p0;
         p0       = pops;
         tx_start = 1'b1;
         tx_len   = 11'd8;
         @(negedge clk);
         tx_start = 1'b0;
         repeat (18) @(negedge clk);
         chk("rst_mid_tx_en", mii_tx_en, 1);
         rst_n = 1'b0;
         #1;
         chk("rst_mid_outputs",
             {22'd0, fifo_rd, mii_txd, mii_tx_en, mii_tx_er, busy, done, underflow}, 32'd0);
         repeat (5) @(negedge clk);
         chk("rst_mid_fifo_cnt", fifo_cnt, 1);
         chk("rst_mid_pops", pops - p0, 1);
         chk("rst_mid_done", done, 0);
         void'(pend.pop_front());
      end
      rst_n = 1'b1;
      run_frame(4, 1'b0);

      chk("illegal_pops", bad_pops, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
